// File: rtl/rr_arb_mux.sv
// Registered N-to-1 channel mux with valid/ready handshake and built-in
// round-robin or fixed-priority arbitration; one output pipeline stage.
module rr_arb_mux #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [CHANNELS*WIDTH-1:0]           in_data,
    input  logic [CHANNELS-1:0]                 in_valid,
    output logic [CHANNELS-1:0]                 in_ready,
    input  logic                                mode,
    output logic [WIDTH-1:0]                    out_data,
    output logic [$clog2(CHANNELS)-1:0]         out_sel,
    output logic                                out_valid,
    input  logic                                out_ready
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_last;

    logic             w_found;
    logic [SEL_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_load;

    // Grant search: round-robin starts just after the last granted channel and
    // wraps modulo CHANNELS; fixed priority scans upward from channel 0.
    always_comb begin
        int unsigned t;
        logic [SEL_W-1:0] idx;
        w_found     = 1'b0;
        w_grant_idx = '0;
        t           = 0;
        idx         = '0;
        if (mode) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                idx = SEL_W'(i);
                if (!w_found && in_valid[idx]) begin
                    w_found     = 1'b1;
                    w_grant_idx = idx;
                end
            end
        end else begin
            for (int unsigned k = 1; k <= CHANNELS; k++) begin
                t = 32'(r_last) + k;
                if (t >= CHANNELS) begin
                    t = t - CHANNELS;
                end
                idx = SEL_W'(t);
                if (!w_found && in_valid[idx]) begin
                    w_found     = 1'b1;
                    w_grant_idx = idx;
                end
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_load = (!r_out_valid || out_ready) && (|in_valid);

    // in_ready is gated by reset_n so no producer sees an accept while in reset.
    always_comb begin
        in_ready = '0;
        if (reset_n && w_load && w_found) begin
            in_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_last      <= SEL_W'(CHANNELS - 1);
        end else if (w_load && w_found) begin
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_grant_idx;
            r_out_valid <= 1'b1;
            r_last      <= w_grant_idx;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux: an 8-channel instance plus a
// 5-channel instance for wrap/skip behaviour of the round-robin pointer.
module tb_rr_arb_mux;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset_n;

    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    logic [5*WIDTH-1:0] d5_in_data;
    logic [4:0]         d5_in_valid;
    logic [4:0]         d5_in_ready;
    logic               d5_mode;
    logic [WIDTH-1:0]   d5_out_data;
    logic [2:0]         d5_out_sel;
    logic               d5_out_valid;
    logic               d5_out_ready;

    int checks;
    int failures;

    logic [WIDTH-1:0] tbl [8];

    rr_arb_mux #(.WIDTH(WIDTH), .CHANNELS(8)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.WIDTH(WIDTH), .CHANNELS(5)) u_dut5 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (d5_in_data),
        .in_valid  (d5_in_valid),
        .in_ready  (d5_in_ready),
        .mode      (d5_mode),
        .out_data  (d5_out_data),
        .out_sel   (d5_out_sel),
        .out_valid (d5_out_valid),
        .out_ready (d5_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_data();
        tbl[0] = 32'd12;   tbl[1] = 32'd31;    tbl[2] = 32'd45; tbl[3] = 32'd121;
        tbl[4] = 32'd1234; tbl[5] = 32'd21312; tbl[6] = 32'd1;  tbl[7] = 32'd6;
        for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = tbl[i];
        for (int i = 0; i < 5; i++) d5_in_data[i*WIDTH +: WIDTH] = 32'(100 + i);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        in_valid     = '0;
        out_ready    = 1'b0;
        mode         = 1'b0;
        d5_in_valid  = '0;
        d5_out_ready = 1'b0;
        d5_mode      = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_data();
        mode         = 1'b0;
        out_ready    = 1'b0;
        in_valid     = 8'hFF;
        d5_in_valid  = '0;
        d5_out_ready = 1'b0;
        d5_mode      = 1'b0;
        reset_n      = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 32'd0) begin failures++;
            $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_sel !== 3'd0) begin failures++;
            $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
        checks++; if (in_ready !== 8'h00) begin failures++;
            $display("FAIL reset_in_ready got=%h exp=00", in_ready); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 8'h00) begin failures++;
            $display("FAIL reset_held got valid=%0b rdy=%h exp valid=0 rdy=00",
                     out_valid, in_ready); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h01) begin failures++;
            $display("FAIL reset_first_grant got=%h exp=01", in_ready); end
        in_valid = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== tbl[k % 8]) begin
                failures++;
                $display("FAIL rr_step%0d got v=%0b sel=%0d data=%0d exp v=1 sel=%0d data=%0d",
                         k, out_valid, out_sel, out_data, k % 8, tbl[k % 8]);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 8'b1010_0100;
        #1;
        checks++; if (in_ready !== 8'h04) begin failures++;
            $display("FAIL fp_in_ready got=%h exp=04", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 32'd45) begin
                failures++;
                $display("FAIL fp_ch2_%0d got v=%0b sel=%0d data=%0d exp v=1 sel=2 data=45",
                         k, out_valid, out_sel, out_data);
            end
        end
        in_valid = 8'b1010_0000;
        @(negedge clk);
        checks++;
        if (out_sel !== 3'd5 || out_data !== 32'd21312) begin
            failures++;
            $display("FAIL fp_ch5 got sel=%0d data=%0d exp sel=5 data=21312", out_sel, out_data);
        end
        in_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        mode      = 1'b0;
        out_ready = 1'b0;
        in_valid  = 8'h10;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd4 || out_data !== 32'd1234) begin
            failures++;
            $display("FAIL bp_load got v=%0b sel=%0d data=%0d exp v=1 sel=4 data=1234",
                     out_valid, out_sel, out_data);
        end
        in_valid = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (in_ready !== 8'h00 || out_valid !== 1'b1 || out_sel !== 3'd4 ||
                out_data !== 32'd1234) begin
                failures++;
                $display("FAIL bp_stall%0d got rdy=%h v=%0b sel=%0d data=%0d exp 00/1/4/1234",
                         k, in_ready, out_valid, out_sel, out_data);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h20) begin failures++;
            $display("FAIL bp_release_ready got=%h exp=20", in_ready); end
        @(negedge clk);
        checks++;
        if (out_sel !== 3'd5 || out_data !== 32'd21312) begin
            failures++;
            $display("FAIL bp_next got sel=%0d data=%0d exp sel=5 data=21312", out_sel, out_data);
        end
        in_valid  = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_wrap_skip();
        logic [2:0] exp_sel [3];
        exp_sel[0] = 3'd4; exp_sel[1] = 3'd1; exp_sel[2] = 3'd4;
        do_reset();
        d5_mode      = 1'b0;
        d5_out_ready = 1'b1;
        d5_in_valid  = 5'b01000;
        @(negedge clk);
        checks++; if (d5_out_sel !== 3'd3 || d5_out_data !== 32'd103) begin failures++;
            $display("FAIL wrap_setup got sel=%0d data=%0d exp sel=3 data=103",
                     d5_out_sel, d5_out_data); end
        d5_in_valid = 5'b10010;
        #1;
        checks++; if (d5_in_ready !== 5'b10000) begin failures++;
            $display("FAIL wrap_ready got=%b exp=10000", d5_in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (d5_out_valid !== 1'b1 || d5_out_sel !== exp_sel[k] ||
                d5_out_data !== 32'(100 + 32'(exp_sel[k]))) begin
                failures++;
                $display("FAIL wrap_step%0d got v=%0b sel=%0d data=%0d exp sel=%0d",
                         k, d5_out_valid, d5_out_sel, d5_out_data, exp_sel[k]);
            end
        end
        d5_in_valid  = '0;
        d5_out_ready = 1'b0;
    endtask

    task automatic test_drain_reset();
        do_reset();
        mode      = 1'b0;
        out_ready = 1'b0;
        in_valid  = 8'h80;
        tbl[7]    = 32'd3123;
        in_data[7*WIDTH +: WIDTH] = tbl[7];
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd7 || out_data !== 32'd3123) begin
            failures++;
            $display("FAIL drain_load got v=%0b sel=%0d data=%0d exp v=1 sel=7 data=3123",
                     out_valid, out_sel, out_data);
        end
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'd7 || out_data !== 32'd3123) begin
            failures++;
            $display("FAIL drain_empty got v=%0b sel=%0d data=%0d exp v=0 sel=7 data=3123",
                     out_valid, out_sel, out_data);
        end
        out_ready = 1'b0;
        in_valid  = 8'h80;
        @(negedge clk);
        in_valid = '0;
        checks++; if (out_valid !== 1'b1) begin failures++;
            $display("FAIL drain_reload got v=%0b exp=1", out_valid); end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_sel !== 3'd0) begin
            failures++;
            $display("FAIL midreset got v=%0b sel=%0d data=%0d exp v=0 sel=0 data=0",
                     out_valid, out_sel, out_data);
        end
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 8'hFF;
        #1;
        checks++; if (in_ready !== 8'h01) begin failures++;
            $display("FAIL midreset_ptr got=%h exp=01", in_ready); end
        in_valid = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        in_data    = '0;
        d5_in_data = '0;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_wrap_skip();
        test_drain_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised, registered N-to-1 channel multiplexer with per-channel valid/ready handshake and built-in arbitration (round-robin or fixed-priority), replacing hand-driven select lines. Sits between multiple producers (e.g. writeback sources, memory/IO request ports) and one shared consumer. One pipeline register on the output, so it gives full throughput with 1-cycle latency.

Parameters:
WIDTH, 32, data width per channel in bits (>=1)
CHANNELS, 8, number of input channels (>=2, need not be a power of two)
SEL_W, $clog2(CHANNELS), derived localparam, width of channel index

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_data  input  CHANNELS*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  channel i has data
in_ready  output  CHANNELS  channel i accepted this cycle
mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
out_data  output  WIDTH  registered selected data
out_sel  output  SEL_W  index of channel that supplied out_data
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (reset_n low, async): out_valid=0, out_data=0, out_sel=0, rr pointer last=CHANNELS-1 (channel 0 has first priority). in_ready forced all-0 while reset_n low.
- load_en = (!out_valid || out_ready) && |in_valid.
- Grant (combinational, one-hot or none):
  - mode=0: first i with in_valid[i], searching last+1, last+2, ... modulo CHANNELS (wrap from CHANNELS-1 to 0; index never >= CHANNELS).
  - mode=1: lowest i with in_valid[i].
- in_ready[i] = load_en && grant==i. At most one bit set. in_ready may depend on in_valid; in_valid must not depend on in_ready.
- Input transfer on channel i: in_valid[i] && in_ready[i]. Next edge: out_data<=in_data[i], out_sel<=i, out_valid<=1, last<=i (pointer updates in both modes, only on a transfer).
- Output transfer: out_valid && out_ready. If there is no input transfer in the same cycle, out_valid<=0 next edge; out_data/out_sel hold their old values.
- Simultaneous output drain + input load: out_valid stays 1, new data appears next cycle (1 word/cycle sustained).
- Stall (out_valid && !out_ready): out_data, out_sel, out_valid stable; all in_ready=0; last unchanged.
- Latency: input accept at edge N -> out_valid high after edge N. No combinational path from in_data to out_data.
- mode is sampled every cycle, so a change takes effect on the next grant. The pointer is preserved across mode changes.
- No valid inputs: no grant, registers hold (except out_valid clearing on drain).
- Reset mid-operation: held word is discarded, out_valid=0 immediately (async), pointer returns to CHANNELS-1.

Test Plan:
- Reset: assert reset_n=0 with in_valid=8'hFF -> out_valid=0, out_data=0, out_sel=0, in_ready=0 during reset. Release -> first grant is ch0.
- Round-robin fairness: mode=0, out_ready=1, all 8 valid, data ch0..7 = 12,31,45,121,1234,21312,1,6 -> out_sel sequence 0,1,...,7,0 on consecutive cycles with matching out_data, out_valid held high.
- Fixed priority: mode=1, in_valid=8'b1010_0100, out_ready=1 -> ch2 granted every cycle (out_data=45). Drop ch2 -> ch5 (21312).
- Backpressure: out_valid=1 holding 1234 (sel 4), out_ready=0 for 5 cycles with other inputs valid -> in_ready=0 and out_data/out_sel stable. Raise out_ready -> next grant is from pointer 5 onward.
- Wrap/skip: CHANNELS=5 instance, mode=0, last=3, only ch1 and ch4 valid -> grants 4 then 1 then 4; out_sel never >=5.
- Drain + reset mid-stream: single ch7 word 3123 accepted, then out_ready=1 with no valid inputs -> out_valid falls next cycle. Reload, then pulse reset_n low mid-stall -> out_valid=0 immediately.
